cc_last_register_writer: RTL and testbench
==========================================

Name: cc_last_register_writer

Overview:
- Write side of the goal-row ("last register") interface in the Frogger datapath.
- Each time the frog reaches the top row, the frog's one-hot column is accepted and OR-ed into the goal register, and filled slots are counted.
- A full goal row is flagged.
- dataLastRegister_OutBUS drives the comparator that decides win or collision for the game FSM.

Parameters:
- LASTREGISTERWRITER_DATAWIDTH, 8, width of the goal row and frog column bus.
- LASTREGISTERWRITER_COUNTWIDTH, 4, width of the filled-slot counter; must hold DATAWIDTH.
- LASTREGISTERWRITER_HOLDCYCLES, 4, cycles the full state is held before auto-clear (used only with the optional feature).

Ports:
- CC_LastRegisterWRITER_CLOCK_50  in  1  system clock, rising edge.
- CC_LastRegisterWRITER_RESET_InLow  in  1  synchronous reset, active-low.
- CC_LastRegisterWRITER_frog_InBUS  in  DATAWIDTH  frog column in the top row, expected one-hot.
- CC_LastRegisterWRITER_arrive_InLow  in  1  write request, active-low, level-held until ack.
- CC_LastRegisterWRITER_clear_InLow  in  1  level restart, active-low, one-cycle pulse.
- CC_LastRegisterWRITER_dataLastRegister_OutBUS  out  DATAWIDTH  goal register contents.
- CC_LastRegisterWRITER_ack_OutLow  out  1  write handshake acknowledge, active-low.
- CC_LastRegisterWRITER_collision_OutLow  out  1  rejected write, active-low, 1-cycle pulse.
- CC_LastRegisterWRITER_full_OutLow  out  1  all slots filled, active-low level.
- CC_LastRegisterWRITER_count_OutBUS  out  COUNTWIDTH  number of filled slots.

Behaviour:
- **Clock and reset:** one clock; reset is synchronous and active-low, sampled on the rising edge.
- **Reset values:** dataLastRegister = 0, count = 0, ack = 1, collision = 1, full = 1, state = IDLE.
- **States:**
  - IDLE: wait for arrive_InLow = 0.
  - CHECK: evaluate the frog bus.
  - WRITE: commit.
  - ACK: hold ack.
  - FULL: row complete.
- **IDLE:**
  - On arrive = 0, register frog_InBUS into an internal capture register and go to CHECK.
  - Inputs are sampled only in IDLE.
- **CHECK (one cycle):**
  - Valid = capture is one-hot AND (capture & dataLastRegister) == 0.
  - Valid -> WRITE.
  - Invalid (zero, multi-hot, or slot already set) -> pulse collision = 0 for exactly this cycle, then go to ACK without writing.
- **WRITE (one cycle):**
  - dataLastRegister <= dataLastRegister | capture; count <= count + 1.
  - Next state is ACK.
- **ACK:**
  - ack = 0 while in ACK.
  - Stay until arrive returns to 1 (4-phase handshake).
  - Then: if dataLastRegister is all ones -> FULL; else -> IDLE.
- **Latency:** arrive falling edge sampled to ack low = 3 cycles (IDLE -> CHECK -> WRITE -> ACK); for an invalid write, 2 cycles.
- **FULL:**
  - full = 0.
  - arrive requests are ignored: no ack, no collision.
  - Register and count are held.
- **Count:** saturates at DATAWIDTH and never wraps; count always equals the popcount of dataLastRegister.
- **clear_InLow = 0:**
  - Zeroes dataLastRegister and count, drives ack/collision/full to 1, and forces IDLE.
  - Applies in any state and has priority over every transition, including WRITE in the same cycle (the write is lost).
  - After clear, a still-low arrive is treated as a new request.
- **Reset mid-handshake:** same effect as clear plus the capture register cleared; the initiator must re-request.
- **Output registration:** all outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro LASTREGISTERWRITER_AUTOCLEAR_EN.
- Defined:
  - After entering FULL, an internal counter counts LASTREGISTERWRITER_HOLDCYCLES cycles.
  - It then clears dataLastRegister and count and returns to IDLE.
  - full is low for exactly HOLDCYCLES cycles.
- Not defined: FULL is held indefinitely until clear_InLow or reset; the hold counter is not instantiated.

Test Plan:
1. Reset, then arrive = 0 with frog = 8'b00000100, released after ack -> ack low 3 cycles after sampling; register = 8'h04, count = 1, collision stays 1.
2. Register = 8'h04, request frog = 8'h04, then frog = 8'h06 -> each gives a collision pulse of 1 cycle, then ack; register stays 8'h04, count = 1.
3. Eight valid writes, columns 0..7 -> after the last ack release, register = 8'hFF, count = 8, full = 0; a further arrive gets no ack.
4. clear_InLow = 0 in the same cycle as WRITE for frog = 8'h10 -> register = 0, count = 0, state IDLE, ack not asserted.
5. Reset low during ACK with arrive held low -> outputs return to reset values next edge; after reset, the held arrive restarts the handshake.
6. With LASTREGISTERWRITER_AUTOCLEAR_EN and HOLDCYCLES = 4, fill the row -> full low for exactly 4 cycles, then register = 0, count = 0, IDLE.

Source files
------------

// File: rtl/cc_last_register_writer.sv
// Goal-row ("last register") write side for the Frogger datapath.
// A frog arriving in the top row requests a write with a 4-phase handshake;
// a valid one-hot column not yet occupied is OR-ed into the goal register
// and counted. Invalid requests pulse collision instead. A complete row is
// flagged on full_OutLow.
// Optional build macro: LASTREGISTERWRITER_AUTOCLEAR_EN. When defined, the
// full state clears itself after LASTREGISTERWRITER_HOLDCYCLES cycles.
//
// state | meaning
// IDLE  | wait for arrive low, capture frog column
// CHECK | evaluate captured column (collision low here if invalid)
// WRITE | commit column into goal register, bump count
// ACK   | ack low until arrive released
// FULL  | row complete, requests ignored
module cc_last_register_writer #(
  parameter int LASTREGISTERWRITER_DATAWIDTH  = 8,
  parameter int LASTREGISTERWRITER_COUNTWIDTH = 4,
  parameter int LASTREGISTERWRITER_HOLDCYCLES = 4
) (
  input  logic                                     CC_LastRegisterWRITER_CLOCK_50,
  input  logic                                     CC_LastRegisterWRITER_RESET_InLow,
  input  logic [LASTREGISTERWRITER_DATAWIDTH-1:0]  CC_LastRegisterWRITER_frog_InBUS,
  input  logic                                     CC_LastRegisterWRITER_arrive_InLow,
  input  logic                                     CC_LastRegisterWRITER_clear_InLow,
  output logic [LASTREGISTERWRITER_DATAWIDTH-1:0]  CC_LastRegisterWRITER_dataLastRegister_OutBUS,
  output logic                                     CC_LastRegisterWRITER_ack_OutLow,
  output logic                                     CC_LastRegisterWRITER_collision_OutLow,
  output logic                                     CC_LastRegisterWRITER_full_OutLow,
  output logic [LASTREGISTERWRITER_COUNTWIDTH-1:0] CC_LastRegisterWRITER_count_OutBUS
);

  localparam int DW = LASTREGISTERWRITER_DATAWIDTH;
  localparam int CW = LASTREGISTERWRITER_COUNTWIDTH;

  // Count must be able to reach DATAWIDTH; the hold time must be at least one cycle.
  if (CW < $clog2(DW + 1) || LASTREGISTERWRITER_HOLDCYCLES < 1) begin : g_bad_params
    $error("cc_last_register_writer: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_ACK   = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] cap_q, cap_d;
  logic          cap_ok_q, cap_ok_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          coll_q, coll_d;
  logic          full_q, full_d;
  logic          frog_onehot;
  logic          frog_valid;

`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
  localparam int HW = $clog2(LASTREGISTERWRITER_HOLDCYCLES + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Validity is judged against the register at capture time; the register
  // cannot change between capture and CHECK, so collision can be registered
  // and still land exactly on the CHECK cycle.
  assign frog_onehot = (CC_LastRegisterWRITER_frog_InBUS != '0) &&
                       ((CC_LastRegisterWRITER_frog_InBUS &
                         (CC_LastRegisterWRITER_frog_InBUS - DW'(1))) == '0);
  assign frog_valid  = frog_onehot && ((CC_LastRegisterWRITER_frog_InBUS & data_q) == '0);

  // Next-state and registered-output logic; clear overrides everything last.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cap_d    = cap_q;
    cap_ok_d = cap_ok_q;
    count_d  = count_q;
    ack_d    = 1'b1;
    coll_d   = 1'b1;
    full_d   = 1'b1;
`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
    hold_d   = hold_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!CC_LastRegisterWRITER_arrive_InLow) begin
          cap_d    = CC_LastRegisterWRITER_frog_InBUS;
          cap_ok_d = frog_valid;
          coll_d   = frog_valid;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cap_ok_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        data_d  = data_q | cap_q;
        count_d = (count_q == CW'(DW)) ? count_q : count_q + CW'(1);
        state_d = ST_ACK;
        ack_d   = 1'b0;
      end
      ST_ACK: begin
        if (CC_LastRegisterWRITER_arrive_InLow) begin
          if (&data_q) begin
            state_d = ST_FULL;
            full_d  = 1'b0;
`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
            hold_d  = HW'(LASTREGISTERWRITER_HOLDCYCLES);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ack_d = 1'b0;
        end
      end
      ST_FULL: begin
`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
        if (hold_q == HW'(1)) begin
          data_d  = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
          full_d = 1'b0;
        end
`else
        full_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (!CC_LastRegisterWRITER_clear_InLow) begin
      state_d = ST_IDLE;
      data_d  = '0;
      count_d = '0;
      ack_d   = 1'b1;
      coll_d  = 1'b1;
      full_d  = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CC_LastRegisterWRITER_CLOCK_50) begin
    if (!CC_LastRegisterWRITER_RESET_InLow) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      cap_q    <= '0;
      cap_ok_q <= 1'b0;
      count_q  <= '0;
      ack_q    <= 1'b1;
      coll_q   <= 1'b1;
      full_q   <= 1'b1;
`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cap_q    <= cap_d;
      cap_ok_q <= cap_ok_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      coll_q   <= coll_d;
      full_q   <= full_d;
`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign CC_LastRegisterWRITER_dataLastRegister_OutBUS = data_q;
  assign CC_LastRegisterWRITER_count_OutBUS            = count_q;
  assign CC_LastRegisterWRITER_ack_OutLow              = ack_q;
  assign CC_LastRegisterWRITER_collision_OutLow        = coll_q;
  assign CC_LastRegisterWRITER_full_OutLow             = full_q;

endmodule

// File: tb/tb_cc_last_register_writer.sv
// Directed bench for cc_last_register_writer: a table of handshakes filling
// the goal row (valid and rejected columns), then hand-written sequences for
// the full state, clear racing a write, and reset mid-handshake.
module tb_cc_last_register_writer;

  logic       clk;
  logic       rst_n;
  logic [7:0] frog;
  logic       arrive_n;
  logic       clear_n;
  logic [7:0] data;
  logic       ack_n;
  logic       coll_n;
  logic       full_n;
  logic [3:0] cnt;

  int checks = 0;
  int errors = 0;

  cc_last_register_writer #(
    .LASTREGISTERWRITER_DATAWIDTH (8),
    .LASTREGISTERWRITER_COUNTWIDTH(4),
    .LASTREGISTERWRITER_HOLDCYCLES(4)
  ) dut (
    .CC_LastRegisterWRITER_CLOCK_50               (clk),
    .CC_LastRegisterWRITER_RESET_InLow            (rst_n),
    .CC_LastRegisterWRITER_frog_InBUS             (frog),
    .CC_LastRegisterWRITER_arrive_InLow           (arrive_n),
    .CC_LastRegisterWRITER_clear_InLow            (clear_n),
    .CC_LastRegisterWRITER_dataLastRegister_OutBUS(data),
    .CC_LastRegisterWRITER_ack_OutLow             (ack_n),
    .CC_LastRegisterWRITER_collision_OutLow       (coll_n),
    .CC_LastRegisterWRITER_full_OutLow            (full_n),
    .CC_LastRegisterWRITER_count_OutBUS           (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] frog;
    int         lat;
    int         ncoll;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full 4-phase handshake: returns cycles to ack low and collision-low samples.
  task automatic req(input logic [7:0] f, output int lat, output int ncoll, output int rel);
    arrive_n = 1'b0;
    frog     = f;
    lat      = 0;
    ncoll    = 0;
    rel      = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!coll_n) ncoll++;
      if (!ack_n) begin
        lat = i + 1;
        break;
      end
    end
    arrive_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_n) begin
        rel = i + 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, ncoll, rel, n;

    vecs[0]  = '{8'h04, 3, 0, 8'h04, 4'd1, 1'b1};
    vecs[1]  = '{8'h04, 2, 1, 8'h04, 4'd1, 1'b1};
    vecs[2]  = '{8'h06, 2, 1, 8'h04, 4'd1, 1'b1};
    vecs[3]  = '{8'h00, 2, 1, 8'h04, 4'd1, 1'b1};
    vecs[4]  = '{8'h01, 3, 0, 8'h05, 4'd2, 1'b1};
    vecs[5]  = '{8'h02, 3, 0, 8'h07, 4'd3, 1'b1};
    vecs[6]  = '{8'h08, 3, 0, 8'h0F, 4'd4, 1'b1};
    vecs[7]  = '{8'h10, 3, 0, 8'h1F, 4'd5, 1'b1};
    vecs[8]  = '{8'h20, 3, 0, 8'h3F, 4'd6, 1'b1};
    vecs[9]  = '{8'h40, 3, 0, 8'h7F, 4'd7, 1'b1};
    vecs[10] = '{8'h80, 3, 0, 8'hFF, 4'd8, 1'b0};

    rst_n    = 1'b0;
    frog     = 8'h00;
    arrive_n = 1'b1;
    clear_n  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_data", 32'(data), 32'h00);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_ack", 32'(ack_n), 32'd1);
    check("rst_coll", 32'(coll_n), 32'd1);
    check("rst_full", 32'(full_n), 32'd1);

    for (int i = 0; i < 11; i++) begin
      req(vecs[i].frog, lat, ncoll, rel);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_coll", i), 32'(ncoll), 32'(vecs[i].ncoll));
      check($sformatf("v%0d_rel", i), 32'(rel), 32'd1);
      check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].data));
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      if (i < 10) check($sformatf("v%0d_full", i), 32'(full_n), 32'(vecs[i].full));
    end

`ifdef LASTREGISTERWRITER_AUTOCLEAR_EN
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (full_n) break;
      n++;
      tick();
    end
    check("ac_full_len", 32'(n), 32'd4);
    check("ac_data", 32'(data), 32'h00);
    check("ac_cnt", 32'(cnt), 32'd0);
    req(8'h20, lat, ncoll, rel);
    check("ac_idle_lat", 32'(lat), 32'd3);
    check("ac_idle_data", 32'(data), 32'h20);
`else
    check("v10_full", 32'(full_n), 32'd0);
    arrive_n = 1'b0;
    frog     = 8'h01;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!ack_n || !coll_n || full_n) n++;
    end
    check("full_ignore", 32'(n), 32'd0);
    check("full_data", 32'(data), 32'hFF);
    check("full_cnt", 32'(cnt), 32'd8);
    arrive_n = 1'b1;
    clear_n  = 1'b0;
    tick();
    clear_n = 1'b1;
    check("fclr_data", 32'(data), 32'h00);
    check("fclr_cnt", 32'(cnt), 32'd0);
    check("fclr_full", 32'(full_n), 32'd1);
`endif

    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    req(8'h01, lat, ncoll, rel);
    check("pre_clr_data", 32'(data), 32'h01);
    arrive_n = 1'b0;
    frog     = 8'h10;
    tick();
    tick();
    clear_n  = 1'b0;
    arrive_n = 1'b1;
    tick();
    clear_n = 1'b1;
    check("cw_data", 32'(data), 32'h00);
    check("cw_cnt", 32'(cnt), 32'd0);
    check("cw_ack", 32'(ack_n), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!ack_n || data != 8'h00) n++;
    end
    check("cw_idle", 32'(n), 32'd0);

    arrive_n = 1'b0;
    frog     = 8'h02;
    tick();
    tick();
    tick();
    check("rm_ack_low", 32'(ack_n), 32'd0);
    check("rm_pre_data", 32'(data), 32'h02);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rm_data", 32'(data), 32'h00);
    check("rm_cnt", 32'(cnt), 32'd0);
    check("rm_ack", 32'(ack_n), 32'd1);
    check("rm_coll", 32'(coll_n), 32'd1);
    check("rm_full", 32'(full_n), 32'd1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ack_n) begin
        lat = i + 1;
        break;
      end
    end
    check("rm_relat", 32'(lat), 32'd3);
    check("rm_redata", 32'(data), 32'h02);
    check("rm_recnt", 32'(cnt), 32'd1);
    arrive_n = 1'b1;
    tick();
    check("rm_release", 32'(ack_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
